note_synth: RTL and testbench

- Downstream consumer of the 32-bit note word that the record/play datapath reads from the 64x32 note RAM.
- Decodes up to six simultaneous string/fret positions into square-wave tones at about 48 kHz.
- Mixes the tones into one signed sample and hands it to the audio-codec write interface through a valid/ready handshake.
- Sound is gated by the beat-divider's record_high window, so notes articulate per beat.

---
 rtl/note_synth_pkg.sv | 22 ++
 rtl/note_period_rom.sv | 46 ++++
 rtl/note_synth.sv | 176 +++++++++++++++++
 tb/tb_note_synth.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_synth_pkg.sv
// Shared constants, FSM state type and note-word bit indexing for the note
// synthesiser.
package note_synth_pkg;

    localparam int NUM_STRINGS = 6;
    localparam int NUM_FRETS   = 5;
    localparam int CNT_W       = 10;

    // Stored-fret code for a string with no bit set in the note word.
    localparam logic [2:0] FRET_SILENT = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    function automatic logic [4:0] note_bit(input logic [2:0] fret, input logic [2:0] str);
        return 5'(fret) * 5'd6 + 5'(str);
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Half-period table in sample ticks for each (string, fret) pair; codes
// outside the six strings and five frets return 0, meaning silent.
module note_period_rom (
    input  logic [2:0] str_i,
    input  logic [2:0] fret_i,
    output logic [9:0] half_o
);

    // Index is {string, fret}, written as two octal digits.
    always_comb begin
        case ({str_i, fret_i})
            6'o00: half_o = 10'd291;
            6'o01: half_o = 10'd275;
            6'o02: half_o = 10'd259;
            6'o03: half_o = 10'd245;
            6'o04: half_o = 10'd231;
            6'o10: half_o = 10'd218;
            6'o11: half_o = 10'd206;
            6'o12: half_o = 10'd194;
            6'o13: half_o = 10'd183;
            6'o14: half_o = 10'd173;
            6'o20: half_o = 10'd163;
            6'o21: half_o = 10'd154;
            6'o22: half_o = 10'd146;
            6'o23: half_o = 10'd137;
            6'o24: half_o = 10'd130;
            6'o30: half_o = 10'd122;
            6'o31: half_o = 10'd116;
            6'o32: half_o = 10'd109;
            6'o33: half_o = 10'd103;
            6'o34: half_o = 10'd97;
            6'o40: half_o = 10'd97;
            6'o41: half_o = 10'd92;
            6'o42: half_o = 10'd87;
            6'o43: half_o = 10'd82;
            6'o44: half_o = 10'd77;
            6'o50: half_o = 10'd73;
            6'o51: half_o = 10'd69;
            6'o52: half_o = 10'd65;
            6'o53: half_o = 10'd61;
            6'o54: half_o = 10'd58;
            default: half_o = 10'd0;
        endcase
    end

endmodule

// File: rtl/note_synth.sv
// Six-string square-wave synthesiser: decodes the note word, advances one
// string per cycle after each sample tick and hands the mix to the codec.
module note_synth
    import note_synth_pkg::*;
#(
    parameter int                          SAMPLE_DIV = 1042,
    parameter int                          SAMPLE_W   = 24,
    parameter logic signed [SAMPLE_W-1:0]  AMP        = 24'sd1000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [31:0]         note,
    input  logic                note_valid,
    input  logic                gate,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                audio_ready,
    output logic                overrun
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic signed [SAMPLE_W:0] AMP_X = {AMP[SAMPLE_W-1], AMP};

    function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic signed [SAMPLE_W:0] a);
        return a[SAMPLE_W-1:0];
    endfunction

    logic [TICK_W-1:0]         tick_cnt_q, tick_cnt_d;
    logic                      tick;
    state_e                    state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic signed [SAMPLE_W:0]  acc_q, acc_d;
    logic [29:0]               note_q, note_d, snap_q, snap_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;
    logic                      unused_note_bits;

    logic [2:0]                fret_q  [NUM_STRINGS];
    logic [CNT_W-1:0]          cnt_q   [NUM_STRINGS];
    logic                      phase_q [NUM_STRINGS];

    logic [2:0]                cur_fret, dec_fret, fret_d;
    logic [CNT_W-1:0]          cur_cnt, cnt_d, half, half_m1;
    logic                      cur_phase, phase_d;
    logic signed [SAMPLE_W:0]  term;

    assign unused_note_bits = ^note[31:30];

    assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign note_d     = note_valid ? note[29:0] : note_q;

    // Highest set fret wins for the string being processed this cycle.
    always_comb begin
        dec_fret = FRET_SILENT;
        for (int f = 0; f < NUM_FRETS; f++) begin
            if (snap_q[note_bit(3'(f), idx_q)]) dec_fret = 3'(f);
        end
    end

    note_period_rom u_rom (
        .str_i  (idx_q),
        .fret_i (dec_fret),
        .half_o (half)
    );

    assign half_m1 = (half == '0) ? '0 : half - 1'b1;

    always_comb begin
        cur_fret  = fret_q[idx_q];
        cur_cnt   = cnt_q[idx_q];
        cur_phase = phase_q[idx_q];
        fret_d    = cur_fret;
        cnt_d     = cur_cnt;
        phase_d   = cur_phase;
        if (dec_fret != cur_fret) begin
            fret_d  = dec_fret;
            cnt_d   = half_m1;
            phase_d = 1'b0;
        end else if (cur_fret != FRET_SILENT) begin
            if (cur_cnt == '0) begin
                cnt_d   = half_m1;
                phase_d = ~cur_phase;
            end else begin
                cnt_d = cur_cnt - 1'b1;
            end
        end
        term = '0;
        if (fret_d != FRET_SILENT && gate) term = phase_d ? -AMP_X : AMP_X;
    end

    // A tick arriving while a sample is still being built or held is dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        snap_d    = snap_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    acc_d   = '0;
                    snap_d  = note_d;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term;
                if (tick) overrun_d = 1'b1;
                if (idx_q == 3'(NUM_STRINGS - 1)) begin
                    state_d  = OUT;
                    sample_d = to_sample(acc_q + term);
                    valid_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                if (valid_q && audio_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            note_q     <= '0;
            snap_q     <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            note_q     <= note_d;
            snap_q     <= snap_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < NUM_STRINGS; s++) begin
                fret_q[s]  <= FRET_SILENT;
                cnt_q[s]   <= '0;
                phase_q[s] <= 1'b0;
            end
        end else if (state_q == ACCUM) begin
            fret_q[idx_q]  <= fret_d;
            cnt_q[idx_q]   <= cnt_d;
            phase_q[idx_q] <= phase_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_note_synth.sv
// Randomised bench for note_synth against a per-string tick-count model of
// the square-wave tones.
module tb_note_synth;

    localparam int     DIV  = 16;
    localparam int     SW   = 24;
    localparam longint AMPV = 1000000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   note = '0;
    logic          note_valid = 1'b0;
    logic          gate = 1'b1;
    logic          audio_ready = 1'b1;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          overrun;

    note_synth #(
        .SAMPLE_DIV (DIV),
        .SAMPLE_W   (SW),
        .AMP        (24'sd1000000)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .note         (note),
        .note_valid   (note_valid),
        .gate         (gate),
        .sample       (sample),
        .sample_valid (sample_valid),
        .audio_ready  (audio_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          half_tab [6][5];
    int          m_fret   [6];
    int          m_n      [6];
    logic [31:0] m_note;
    logic        m_gate;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 6; s++) begin
            m_fret[s] = -1;
            m_n[s]    = 0;
        end
    endtask

    // Each string tracks how many ticks it has played its current fret;
    // the phase is which half-period that count falls in.
    task automatic model_step(input logic [31:0] nv, input logic g, output longint exp);
        int fn;
        exp = 0;
        for (int s = 0; s < 6; s++) begin
            fn = -1;
            for (int f = 0; f < 5; f++)
                if (((nv >> (6 * f + s)) & 32'd1) != 0) fn = f;
            if (fn != m_fret[s]) begin
                m_fret[s] = fn;
                m_n[s]    = 0;
            end else if (fn >= 0) begin
                m_n[s]++;
            end
            if (m_fret[s] >= 0 && g)
                exp += (((m_n[s] / half_tab[s][m_fret[s]]) % 2) != 0) ? -AMPV : AMPV;
        end
    endtask

    task automatic get_sample(input string tag, output longint got_v);
        int     waited;
        bit     got;
        longint exp;
        waited = 0;
        got    = 0;
        got_v  = 0;
        while (!got && waited < 4 * DIV) begin
            @(negedge clk);
            waited++;
            if (sample_valid) got = 1;
        end
        if (!got) begin
            check_val({tag, "_timeout"}, 0, 1);
        end else begin
            model_step(m_note, m_gate, exp);
            got_v = longint'($signed(sample));
            check_val(tag, got_v, exp);
            @(posedge clk);
        end
    endtask

    task automatic run_samples(input string tag, input int n);
        longint v;
        for (int i = 0; i < n; i++) get_sample(tag, v);
    endtask

    task automatic set_note(input logic [31:0] v);
        @(posedge clk);
        #1 note = v;
        note_valid = 1'b1;
        m_note = v;
        @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic set_gate(input logic g);
        #1 gate = g;
        m_gate = g;
    endtask

    initial begin
        real    fopen [6];
        longint v;
        longint s0;
        int     k;
        logic [31:0] nv;

        fopen = '{82.41, 110.00, 146.83, 196.00, 246.94, 329.63};
        for (int s = 0; s < 6; s++)
            for (int f = 0; f < 5; f++)
                half_tab[s][f] = $rtoi(48000.0 / (2.0 * fopen[s] * (2.0 ** (f / 12.0))) + 0.5);
        model_reset();
        m_note = '0;
        m_gate = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sample", longint'($signed(sample)), 0);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_overrun", overrun, 0);
        resetn = 1'b1;

        // String 0 open: 291 ticks positive, 291 negative
        set_note(32'h1);
        get_sample("s0_open_first", v);
        check_val("s0_open_first_amp", v, AMPV);
        run_samples("s0_open", 600);

        // Fret bar on string 0 takes priority over the open bit
        set_note(32'h41);
        get_sample("s0_fret1_first", v);
        check_val("s0_fret1_first_amp", v, AMPV);
        run_samples("s0_fret1", 600);
        set_note(32'h0);
        get_sample("note_zero", v);
        check_val("note_zero_val", v, 0);
        run_samples("note_zero", 3);

        // All six strings open, then gated off and back on
        set_note(32'h3F);
        get_sample("chord_first", v);
        check_val("chord_first_6amp", v, 6 * AMPV);
        run_samples("chord", 5);
        set_gate(1'b0);
        for (int i = 0; i < 20; i++) begin
            get_sample("gate_off", v);
            check_val("gate_off_zero", v, 0);
        end
        set_gate(1'b1);
        run_samples("gate_on", 20);

        // Backpressure across two ticks
        #1 audio_ready = 1'b0;
        k = 0;
        while (!sample_valid && k < 4 * DIV) begin
            @(negedge clk);
            k++;
        end
        check_val("bp_valid_seen", sample_valid, 1);
        model_step(m_note, m_gate, v);
        s0 = longint'($signed(sample));
        check_val("bp_sample", s0, v);
        repeat (2 * DIV + 2) @(negedge clk);
        check_val("bp_valid_held", sample_valid, 1);
        check_val("bp_sample_held", longint'($signed(sample)), s0);
        check_val("bp_overrun", overrun, 1);
        audio_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_released_valid", sample_valid, 0);
        check_val("bp_overrun_sticky", overrun, 1);
        run_samples("after_bp", 10);

        // New note latched while a sample is accumulating
        get_sample("pre_mid_note", v);
        repeat (DIV - 7) @(posedge clk);
        #1 note = 32'h2;
        note_valid = 1'b1;
        @(posedge clk);
        #1 note_valid = 1'b0;
        get_sample("mid_note_old", v);
        m_note = 32'h2;
        get_sample("mid_note_new", v);
        check_val("mid_note_new_amp", v, AMPV);
        run_samples("s1_open", 450);

        // Reset in the middle of ACCUM
        get_sample("pre_reset", v);
        repeat (DIV - 7) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        check_val("midrst_sample", longint'($signed(sample)), 0);
        check_val("midrst_valid", sample_valid, 0);
        check_val("midrst_overrun", overrun, 0);
        model_reset();
        m_note = '0;
        k = 0;
        while (k < 4 * DIV) begin
            @(posedge clk);
            k++;
            #1;
            if (sample_valid) break;
        end
        check_val("midrst_latency", k, DIV + 6);
        model_step(m_note, m_gate, v);
        check_val("midrst_first_sample", longint'($signed(sample)), v);
        @(posedge clk);

        // Random note words and gate settings
        for (int it = 0; it < 25; it++) begin
            nv = $urandom & $urandom;
            set_note(nv);
            set_gate($urandom_range(0, 3) != 0);
            run_samples("random", $urandom_range(1, 40));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
